// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word size, PC step,
// default reset PC, FSM state encoding and a PC alignment helper.
package fetch_unit_pkg;

    localparam int unsigned     ILEN             = 32;
    localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    // Force a PC onto a word boundary.
    function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] pc);
        return pc & ~{{(ILEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory request/response,
// redirect input and the decoder-facing instruction handshake.
//   master : fetch unit side
//   slave  : memory / decoder / branch-unit side
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [ILEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [ILEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid,
               redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid,
               redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of {pc, instr} fetch results.
//   clk, rst_n : clock, async active-low reset
//   flush      : empties the buffer (takes priority over push/pop)
//   push/data  : write to tail
//   pop        : advance head
//   head       : oldest entry
//   count      : occupancy 0..2
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * ILEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A full buffer can still accept a push in the same cycle it pops.
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, keeps at most one request
// outstanding, buffers up to two responses and handles redirects.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_unit_if.master (imem request/response, redirect,
//                decoder handshake)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_REQ  | nothing outstanding; imem_req raised whenever buffer has room
// ST_WAIT | one request accepted, awaiting imem_rvalid
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    fetch_unit_if.master bus
);

    fetch_state_t      state;
    logic              run;
    logic              discard;
    logic [ILEN-1:0]   fetch_pc;
    logic [ILEN-1:0]   req_pc;
    logic [1:0]        count;
    logic [2*ILEN-1:0] head;
    logic              outstanding;
    logic              rsp;
    logic              hs;
    logic              redirect;
    logic              buf_valid;
    logic              pop;
    logic              push;
    logic              room;

    assign outstanding = (state == ST_WAIT);
    assign rsp         = bus.imem_rvalid && outstanding;
    assign redirect    = bus.redirect_valid;
    assign buf_valid   = (count != 2'd0);
    assign pop         = buf_valid && bus.instr_ready && !redirect;
    assign push        = rsp && !discard && !redirect;

    // The outstanding request still counts while its response returns, so
    // a slot is reserved for it; a pop this cycle frees one.
    assign room = ({1'b0, count} + {2'b00, outstanding} - {2'b00, pop}) < 3'd2;

    // Request is combinational so a new fetch can issue in the same cycle
    // the previous response lands, sustaining one instruction per cycle.
    assign bus.imem_req  = run && (!outstanding || bus.imem_rvalid) && room;
    assign bus.imem_addr = fetch_pc;
    assign hs            = bus.imem_req && bus.imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_REQ;
            run      <= 1'b0;
            discard  <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            run <= 1'b1;

            case (state)
                ST_REQ:  if (hs)          state <= ST_WAIT;
                ST_WAIT: if (rsp && !hs)  state <= ST_REQ;
                default:                  state <= ST_REQ;
            endcase

            if (hs) begin
                req_pc <= fetch_pc;
            end

            if (redirect) begin
                fetch_pc <= align_pc(bus.redirect_pc);
            end else if (hs) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end

            // Only one request can be in flight, so the flag covers exactly
            // the request left behind by the redirect (if any).
            if (redirect) begin
                discard <= hs || (outstanding && !rsp);
            end else if (rsp) begin
                discard <= 1'b0;
            end
        end
    end

    fetch_fifo #(.WIDTH(2 * ILEN)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data ({req_pc, bus.imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign bus.instr_valid = buf_valid;
    assign bus.instr       = head[ILEN-1:0];
    assign bus.instr_pc    = head[2*ILEN-1:ILEN];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        tbl[18];
    int          n_total = 0;
    int          n_bad   = 0;
    int          consumed = 0;
    logic [31:0] mem_q[$];
    logic [31:0] req_exp;
    logic [31:0] exp_pc;
    logic        post_redir;

    function automatic vec_t mk(logic r, logic q, logic [31:0] a, logic v, logic [31:0] p);
        vec_t t;
        t.rdy = r; t.exp_req = q; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
        return t;
    endfunction

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, update the reference
    // model (program-order PC stream + in-order memory with a request queue).
    task automatic step(input logic rdy, input logic mrdy, input logic rv_en,
                        input logic spur, input logic redir, input logic [31:0] tgt);
        logic hs;
        @(negedge clk);
        bus.instr_ready    = rdy;
        bus.imem_ready     = mrdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        if (mem_q.size() > 0 && rv_en) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mem_q.pop_front());
        end else if (mem_q.size() == 0 && spur) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom();
        end
        #1;
        if (post_redir) check("valid_after_redirect", 32'(bus.instr_valid), 32'd0);
        post_redir = redir;
        hs = bus.imem_req && mrdy;
        if (hs) begin
            check("req_addr", bus.imem_addr, req_exp);
            check("one_outstanding", 32'(mem_q.size()), 32'd0);
            mem_q.push_back(bus.imem_addr);
        end
        if (redir)   req_exp = {tgt[31:2], 2'b00};
        else if (hs) req_exp = req_exp + 32'd4;
        if (bus.instr_valid && rdy && !redir) begin
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instr", bus.instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (redir) exp_pc = {tgt[31:2], 2'b00};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #1;
        check("rst_req",   32'(bus.imem_req),    32'd0);
        check("rst_addr",  bus.imem_addr,        TB_RESET_PC);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr,            32'd0);
        check("rst_pc",    bus.instr_pc,         32'd0);
        mem_q.delete();
        req_exp    = TB_RESET_PC;
        exp_pc     = TB_RESET_PC;
        post_redir = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic        found;
    logic        r_rdy, r_mrdy, r_rv, r_spur, r_redir;
    logic [31:0] r_tgt;
    int          consumed_before;

    initial begin
        tbl[0]  = mk(1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
        tbl[1]  = mk(1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
        tbl[2]  = mk(1'b1, 1'b1, 32'h08, 1'b1, 32'h00);
        tbl[3]  = mk(1'b1, 1'b1, 32'h0C, 1'b1, 32'h04);
        tbl[4]  = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
        tbl[5]  = mk(1'b1, 1'b1, 32'h14, 1'b1, 32'h0C);
        tbl[6]  = mk(1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
        tbl[7]  = mk(1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
        tbl[8]  = mk(1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
        tbl[9]  = mk(1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
        tbl[10] = mk(1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
        tbl[11] = mk(1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
        tbl[12] = mk(1'b1, 1'b1, 32'h18, 1'b1, 32'h10);
        tbl[13] = mk(1'b1, 1'b1, 32'h1C, 1'b1, 32'h14);
        tbl[14] = mk(1'b1, 1'b1, 32'h20, 1'b1, 32'h18);
        tbl[15] = mk(1'b1, 1'b1, 32'h24, 1'b1, 32'h1C);
        tbl[16] = mk(1'b1, 1'b1, 32'h28, 1'b1, 32'h20);
        tbl[17] = mk(1'b1, 1'b1, 32'h2C, 1'b1, 32'h24);

        // Zero-wait streaming, decoder stall for six cycles, then release.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rdy, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check($sformatf("tbl%0d_req", i),   32'(bus.imem_req),    32'(tbl[i].exp_req));
            check($sformatf("tbl%0d_addr", i),  bus.imem_addr,        tbl[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) check($sformatf("tbl%0d_pc", i), bus.instr_pc, tbl[i].exp_pc);
        end

        // Memory not ready for three cycles at 0x10.
        do_reset();
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            check("stall_req",  32'(bus.imem_req), 32'd1);
            check("stall_addr", bus.imem_addr,     32'h10);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("accept_addr", bus.imem_addr, 32'h10);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("after_accept_addr", bus.imem_addr, 32'h14);

        // Redirect to 0x103 while the request for 0x20 is outstanding.
        do_reset();
        repeat (9) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            if (bus.instr_valid) begin
                check("redir_first_pc", bus.instr_pc, 32'h100);
                found = 1'b1;
            end
        end
        check("redir_seen", 32'(found), 32'd1);

        // Full buffer, redirect with stray rvalid and decoder ready.
        do_reset();
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("full_no_req", 32'(bus.imem_req), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("flush_valid", 32'(bus.instr_valid), 32'd0);
        check("flush_addr",  bus.imem_addr,        32'h200);
        check("flush_req",   32'(bus.imem_req),    32'd1);

        // Reset while waiting on a response; restart at RESET_PC.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("restart_req",  32'(bus.imem_req), 32'd1);
        check("restart_addr", bus.imem_addr,     TB_RESET_PC);

        // Randomized traffic against the program-order model.
        consumed_before = consumed;
        for (int c = 0; c < 3000; c++) begin
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_mrdy  = ($urandom_range(0, 9) < 7);
            r_rv    = ($urandom_range(0, 9) < 6);
            r_spur  = ($urandom_range(0, 9) == 0);
            r_redir = ($urandom_range(0, 24) == 0);
            r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom();
            step(r_rdy, r_mrdy, r_rv, r_spur, r_redir, r_tgt);
        end
        check("random_progress", 32'((consumed - consumed_before) > 300), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
